// File: rtl/stage_seq_if.sv
// stage_seq handshake/bus bundle.
// master = sequencer environment side, slave = stage_seq.
interface stage_seq_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            stop;
  logic            fetch_ack;
  logic [3:0]      opcode;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            fetch_req;
  logic            dec_en;
  logic            exec_en;
  logic            wb_en;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic [15:0]     retired;

  modport master (
    output start, stop, fetch_ack,
    output opcode, br_taken, br_target,
    input  fetch_req, dec_en, exec_en, wb_en,
    input  pc, busy, halted, retired
  );

  modport slave (
    input  start, stop, fetch_ack,
    input  opcode, br_taken, br_target,
    output fetch_req, dec_en, exec_en, wb_en,
    output pc, busy, halted, retired
  );
endinterface

// File: rtl/stage_seq.sv
// Four-stage instruction sequencer FSM.
// Define STAGE_SEQ_RETIRE_CNT_EN to build the retired counter.
module stage_seq #(
  parameter int          PC_W     = 8,
  parameter int          RESET_PC = 0,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input logic         clk,
  input logic         rst,
  stage_seq_if.slave  bus
);

  localparam logic [PC_W-1:0] RST_PC =
    PC_W'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t          state;
  state_t          nxt;
  logic            fetch_req_q;
  logic            dec_en_q;
  logic            exec_en_q;
  logic            wb_en_q;
  logic            busy_q;
  logic            halted_q;
  logic [PC_W-1:0] pc_q;

  // Next-state selection for the sequencer.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (bus.start) nxt = FETCH;
      FETCH:  if (bus.fetch_ack) nxt = DECODE;
      DECODE: nxt = EXEC;
      EXEC:   nxt = (bus.opcode == HALT_OP)
                    ? HALT : WB;
      WB:     nxt = bus.stop ? IDLE : FETCH;
      HALT:   if (bus.start) nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end

  // State, registered stage strobes and pc.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_req_q <= 1'b0;
      dec_en_q    <= 1'b0;
      exec_en_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      pc_q        <= RST_PC;
    end else begin
      state       <= nxt;
      fetch_req_q <= (nxt == FETCH);
      dec_en_q    <= (nxt == DECODE);
      exec_en_q   <= (nxt == EXEC);
      wb_en_q     <= (nxt == WB);
      busy_q      <= (nxt == FETCH) ||
                     (nxt == DECODE) ||
                     (nxt == EXEC) ||
                     (nxt == WB);
      halted_q    <= (nxt == HALT);
      if (state == WB)
        pc_q <= bus.br_taken
                ? bus.br_target
                : pc_q + 1'b1;
      else if (state == HALT && bus.start)
        pc_q <= pc_q + 1'b1;
    end
  end

`ifdef STAGE_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;

  // Saturating count of completed writebacks.
  always_ff @(posedge clk) begin
    if (!rst)
      retired_q <= 16'd0;
    else if (state == WB &&
             retired_q != 16'hFFFF)
      retired_q <= retired_q + 16'd1;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = 16'd0;
`endif

  assign bus.fetch_req = fetch_req_q;
  assign bus.dec_en    = dec_en_q;
  assign bus.exec_en   = exec_en_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.pc        = pc_q;

endmodule

// File: doc/stage_seq.md
STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter HALT_OP, default 4'hF, giving the opcode that halts sequencing.
REQ-004 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 start  input  1  leave IDLE or HALT and begin fetching.
REQ-007 stop  input  1  return to IDLE after the current writeback.
REQ-008 fetch_ack  input  1  instruction memory has valid instruction data this cycle.
REQ-009 opcode  input  4  decoded opcode, valid during EXEC.
REQ-010 br_taken  input  1  execute stage redirects the PC; sampled in WB.
REQ-011 br_target  input  PC_W  redirect address; sampled in WB.
REQ-012 fetch_req  output  1  fetch request; held high throughout FETCH.
REQ-013 dec_en  output  1  decode strobe; one cycle.
REQ-014 exec_en  output  1  execute strobe; one cycle.
REQ-015 wb_en  output  1  register-file writeback strobe; one cycle.
REQ-016 pc  output  PC_W  current instruction address.
REQ-017 busy  output  1  high in FETCH, DECODE, EXEC and WB.
REQ-018 halted  output  1  high in HALT.
REQ-019 retired  output  16  count of instructions that completed WB.

Function
REQ-020 The FSM SHALL have exactly six states: IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-021 All outputs SHALL be registered or decoded from state only; no input SHALL have a combinational path to any output.
REQ-022 IDLE: the FSM SHALL go to FETCH on the edge where start=1, and otherwise stay in IDLE.
REQ-023 FETCH: fetch_req SHALL be 1; the FSM SHALL go to DECODE on the edge where fetch_ack=1; there is no timeout.
REQ-024 DECODE: dec_en SHALL be 1 for exactly one cycle, and the FSM SHALL then go to EXEC.
REQ-025 EXEC: exec_en SHALL be 1 for one cycle; the FSM SHALL go to HALT if opcode==HALT_OP, otherwise to WB.
REQ-026 The HALT opcode SHALL NOT assert wb_en, change pc or increment retired.
REQ-027 WB: wb_en SHALL be 1 for one cycle, and pc SHALL be loaded with br_target if br_taken=1, otherwise pc+1.
REQ-028 The pc+1 increment SHALL wrap modulo 2^PC_W (for PC_W=8, 8'hFF goes to 8'h00).
REQ-029 WB: retired SHALL increment by 1 and saturate at 16'hFFFF.
REQ-030 WB exit: the FSM SHALL go to IDLE if stop=1, otherwise to FETCH.
REQ-031 stop SHALL be ignored in every state except WB.
REQ-032 HALT: halted SHALL be 1; on start=1 the FSM SHALL set pc<=pc+1 (wrapping) and go to FETCH.
REQ-033 start SHALL be ignored in FETCH, DECODE, EXEC and WB.
REQ-034 At most one of fetch_req, dec_en, exec_en and wb_en SHALL be 1 in any cycle.
REQ-035 Minimum instruction period SHALL be 4 cycles (fetch_ack=1 in the first FETCH cycle); each extra cycle of fetch_ack=0 SHALL add exactly one cycle.
REQ-036 With br_taken=1 and br_target equal to pc, the PC SHALL remain unchanged (self-loop allowed).

Reset
REQ-037 On a clk edge with rst=0, the FSM SHALL enter IDLE from any state, including mid-instruction.
REQ-038 The same reset edge SHALL set pc=RESET_PC and retired=0.
REQ-039 The same reset edge SHALL set fetch_req, dec_en, exec_en, wb_en, busy and halted to 0.
REQ-040 An instruction interrupted by reset SHALL NOT produce wb_en and SHALL NOT count as retired.

Configuration
REQ-041 Macro STAGE_SEQ_RETIRE_CNT_EN: when defined, the retired counter SHALL be implemented per REQ-029.
REQ-042 When STAGE_SEQ_RETIRE_CNT_EN is undefined, retired SHALL be constant 0 and no counter register SHALL be present; all other behaviour is unchanged.

Verification
REQ-043 Reset, then start=1 for one cycle, fetch_ack=1, opcode=0, no branch -> fetch_req/dec_en/exec_en/wb_en in consecutive cycles; pc 0->1; retired=1.
REQ-044 Hold fetch_ack=0 for 3 FETCH cycles, then 1 -> fetch_req high for 4 cycles; dec_en exactly one cycle later.
REQ-045 In WB with pc=8'h10, br_taken=1, br_target=8'h42 -> next FETCH with pc=8'h42; with br_taken=0 at pc=8'hFF -> pc=8'h00.
REQ-046 opcode=4'hF in EXEC -> HALT, halted=1, no wb_en, pc and retired unchanged; start=1 -> pc+1, then FETCH.
REQ-047 rst=0 asserted during EXEC -> next cycle IDLE, pc=RESET_PC, retired=0, all strobes 0; stop=1 in WB -> IDLE with busy=0.
REQ-048 Build without STAGE_SEQ_RETIRE_CNT_EN and run 300 instructions -> retired stays 0; with the macro -> retired=300.
